// File: rtl/rr_packet_mux_arbiter_if.sv
// Bundles the four requester inputs and the single output channel of the
// round-robin packet mux. The master side is the producer/consumer
// environment and the slave side is the arbiter itself.
interface rr_packet_mux_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       out_sel;
  logic             out_ready;

  modport master (
    output in_valid, in_last, d0, d1, d2, d3, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_last, d0, d1, d2, d3, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/rr_packet_mux_arbiter.sv
// Four-way round-robin packet arbiter feeding one registered valid/ready
// output stage. A requester that wins keeps the channel until its last
// beat is taken; the pointer then moves just past it.
module rr_packet_mux_arbiter #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_packet_mux_arbiter_if.slave bus
);

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [1:0]       r_owner;
  logic [1:0]       w_ownerNext;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptrNext;

  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;
  logic             r_outLast;
  logic [1:0]       r_outSel;

  logic             w_load;
  logic             w_anyValid;
  logic [1:0]       w_winner;
  logic [1:0]       w_grantIdx;
  logic [3:0]       w_inReady;
  logic             w_accept;
  logic             w_acceptLast;
  logic [WIDTH-1:0] w_grantData;

  assign w_load       = !r_outValid || bus.out_ready;
  assign w_anyValid   = |bus.in_valid;
  assign w_grantIdx   = (r_state == ST_LOCKED) ? r_owner : w_winner;
  assign w_accept     = |(bus.in_valid & w_inReady);
  assign w_acceptLast = bus.in_last[w_grantIdx];

  // Find the first valid requester starting at the pointer; scanning the
  // offsets downwards lets the smallest offset overwrite the others.
  always_comb begin
    w_winner = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.in_valid[r_ptr + 2'(k)]) begin
        w_winner = r_ptr + 2'(k);
      end
    end
  end

  // Select the data beat of whichever requester currently holds the grant.
  always_comb begin
    case (w_grantIdx)
      2'd0:    w_grantData = bus.d0;
      2'd1:    w_grantData = bus.d1;
      2'd2:    w_grantData = bus.d2;
      default: w_grantData = bus.d3;
    endcase
  end

  // Next-state logic: a non-last beat locks onto its source, a last beat
  // frees the channel and advances the pointer past the finished requester.
  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    w_ptrNext   = r_ptr;
    if (w_accept) begin
      if (w_acceptLast) begin
        w_stateNext = ST_FREE;
        w_ptrNext   = w_grantIdx + 2'd1;
      end else begin
        w_stateNext = ST_LOCKED;
        w_ownerNext = w_grantIdx;
      end
    end
  end

  // Ready generation: only when the output stage can load, and only to the
  // owner while locked (even if it has gone idle) or to the winner otherwise.
  always_comb begin
    w_inReady = 4'b0000;
    if (w_load) begin
      if (r_state == ST_LOCKED) begin
        w_inReady[r_owner] = 1'b1;
      end else if (w_anyValid) begin
        w_inReady[w_winner] = 1'b1;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FREE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
    end else begin
      r_state <= w_stateNext;
      r_owner <= w_ownerNext;
      r_ptr   <= w_ptrNext;
    end
  end

  // Output stage: capture an accepted beat, otherwise drain when allowed to load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outLast  <= 1'b0;
      r_outSel   <= 2'd0;
    end else if (w_load) begin
      if (w_accept) begin
        r_outValid <= 1'b1;
        r_outData  <= w_grantData;
        r_outLast  <= w_acceptLast;
        r_outSel   <= w_grantIdx;
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.out_last  = r_outLast;
  assign bus.out_sel   = r_outSel;

endmodule

// File: tb/tb_rr_packet_mux_arbiter.sv
// Directed self-checking bench for the round-robin packet mux arbiter.
// Inputs change 1 time unit after the rising edge; ready is sampled once
// they settle and registered outputs are sampled just after each edge.
module tb_rr_packet_mux_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_packet_mux_arbiter_if #(.WIDTH(4)) bus ();

  rr_packet_mux_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l,
                               input logic [3:0] a0, input logic [3:0] a1,
                               input logic [3:0] a2, input logic [3:0] a3,
                               input logic ordy);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.d0        = a0;
    bus.d1        = a1;
    bus.d2        = a2;
    bus.d3        = a3;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_in_ready cyc%0d got %b exp 0000", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid cyc%0d got %b exp 0", c, bus.out_valid); end
      checks++; if (bus.out_data !== 4'd0) begin errors++; $display("[TB] FAIL reset_out_data cyc%0d got %0d exp 0", c, bus.out_data); end
      checks++; if (bus.out_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_sel cyc%0d got %0d exp 0", c, bus.out_sel); end
      cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] expRdy;
    applyStimulus(4'b1111, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      expRdy = 4'b0001 << (k % 4);
      checks++; if (bus.in_ready !== expRdy) begin errors++; $display("[TB] FAIL rr_in_ready beat%0d got %b exp %b", k, bus.in_ready, expRdy); end
      cycle();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_out_valid beat%0d got %b exp 1", k, bus.out_valid); end
      checks++; if (bus.out_sel !== 2'(k % 4)) begin errors++; $display("[TB] FAIL rr_out_sel beat%0d got %0d exp %0d", k, bus.out_sel, k % 4); end
      checks++; if (bus.out_data !== 4'((k % 4) + 1)) begin errors++; $display("[TB] FAIL rr_out_data beat%0d got %0d exp %0d", k, bus.out_data, (k % 4) + 1); end
    end
    applyStimulus(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_multi_beat();
    // Single beat from requester 1 moves the pointer to 2.
    applyStimulus(4'b0010, 4'b0010, 4'd0, 4'd9, 4'd0, 4'd0, 1'b1);
    cycle();
    // Requester 2 sends A,B,C while 0 and 3 wait.
    applyStimulus(4'b1101, 4'b1001, 4'd5, 4'd0, 4'hA, 4'd6, 1'b1);
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL mb_ready_A got %b exp 0100", bus.in_ready); end
    cycle();
    checks++; if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 2'd2, 4'hA, 1'b0}) begin errors++; $display("[TB] FAIL mb_beat_A got v%b s%0d d%h l%b exp v1 s2 dA l0", bus.out_valid, bus.out_sel, bus.out_data, bus.out_last); end
    applyStimulus(4'b1101, 4'b1001, 4'd5, 4'd0, 4'hB, 4'd6, 1'b1);
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL mb_ready_B got %b exp 0100", bus.in_ready); end
    cycle();
    checks++; if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 2'd2, 4'hB, 1'b0}) begin errors++; $display("[TB] FAIL mb_beat_B got v%b s%0d d%h l%b exp v1 s2 dB l0", bus.out_valid, bus.out_sel, bus.out_data, bus.out_last); end
    applyStimulus(4'b1101, 4'b1101, 4'd5, 4'd0, 4'hC, 4'd6, 1'b1);
    cycle();
    checks++; if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 2'd2, 4'hC, 1'b1}) begin errors++; $display("[TB] FAIL mb_beat_C got v%b s%0d d%h l%b exp v1 s2 dC l1", bus.out_valid, bus.out_sel, bus.out_data, bus.out_last); end
    applyStimulus(4'b1001, 4'b1001, 4'd5, 4'd0, 4'd0, 4'd6, 1'b1);
    checks++; if (bus.in_ready !== 4'b1000) begin errors++; $display("[TB] FAIL mb_next_ready got %b exp 1000", bus.in_ready); end
    cycle();
    checks++; if ({bus.out_sel, bus.out_data} !== {2'd3, 4'd6}) begin errors++; $display("[TB] FAIL mb_next_req3 got s%0d d%0d exp s3 d6", bus.out_sel, bus.out_data); end
    cycle();
    checks++; if ({bus.out_sel, bus.out_data} !== {2'd0, 4'd5}) begin errors++; $display("[TB] FAIL mb_next_req0 got s%0d d%0d exp s0 d5", bus.out_sel, bus.out_data); end
    applyStimulus(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    cycle();
  endtask

  task automatic test_owner_bubble();
    // Pointer is 1: requester 1 starts a packet ahead of requester 0.
    applyStimulus(4'b0011, 4'b0001, 4'd5, 4'd7, 4'd0, 4'd0, 1'b1);
    checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("[TB] FAIL ob_first_ready got %b exp 0010", bus.in_ready); end
    cycle();
    checks++; if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 2'd1, 4'd7}) begin errors++; $display("[TB] FAIL ob_first_beat got v%b s%0d d%0d exp v1 s1 d7", bus.out_valid, bus.out_sel, bus.out_data); end
    applyStimulus(4'b0001, 4'b0001, 4'd5, 4'd0, 4'd0, 4'd0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("[TB] FAIL ob_hold_ready cyc%0d got %b exp 0010", c, bus.in_ready); end
      cycle();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ob_bubble cyc%0d got %b exp 0", c, bus.out_valid); end
    end
    applyStimulus(4'b0011, 4'b0011, 4'd5, 4'd8, 4'd0, 4'd0, 1'b1);
    checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("[TB] FAIL ob_last_ready got %b exp 0010", bus.in_ready); end
    cycle();
    checks++; if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 2'd1, 4'd8, 1'b1}) begin errors++; $display("[TB] FAIL ob_last_beat got v%b s%0d d%0d l%b exp v1 s1 d8 l1", bus.out_valid, bus.out_sel, bus.out_data, bus.out_last); end
    applyStimulus(4'b0001, 4'b0001, 4'd5, 4'd0, 4'd0, 4'd0, 1'b1);
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL ob_req0_ready got %b exp 0001", bus.in_ready); end
    cycle();
    checks++; if ({bus.out_sel, bus.out_data} !== {2'd0, 4'd5}) begin errors++; $display("[TB] FAIL ob_req0_beat got s%0d d%0d exp s0 d5", bus.out_sel, bus.out_data); end
    applyStimulus(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    cycle();
  endtask

  task automatic test_backpressure();
    // Pointer is 1: requester 2 is the only one valid.
    applyStimulus(4'b0100, 4'b0100, 4'd0, 4'd0, 4'd9, 4'd0, 1'b1);
    cycle();
    applyStimulus(4'b0100, 4'b0100, 4'd0, 4'd0, 4'd3, 4'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready cyc%0d got %b exp 0000", c, bus.in_ready); end
      checks++; if ({bus.out_valid, bus.out_sel, bus.out_data, bus.out_last} !== {1'b1, 2'd2, 4'd9, 1'b1}) begin errors++; $display("[TB] FAIL bp_hold cyc%0d got v%b s%0d d%0d l%b exp v1 s2 d9 l1", c, bus.out_valid, bus.out_sel, bus.out_data, bus.out_last); end
      cycle();
    end
    checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 4'd9}) begin errors++; $display("[TB] FAIL bp_hold_end got v%b d%0d exp v1 d9", bus.out_valid, bus.out_data); end
    applyStimulus(4'b0100, 4'b0100, 4'd0, 4'd0, 4'd3, 4'd0, 1'b1);
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL bp_release_ready got %b exp 0100", bus.in_ready); end
    cycle();
    checks++; if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 2'd2, 4'd3}) begin errors++; $display("[TB] FAIL bp_next_beat got v%b s%0d d%0d exp v1 s2 d3", bus.out_valid, bus.out_sel, bus.out_data); end
    applyStimulus(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    // Pointer is 3: requester 3 opens a multi-beat packet.
    applyStimulus(4'b1000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'hB, 1'b1);
    checks++; if (bus.in_ready !== 4'b1000) begin errors++; $display("[TB] FAIL rm_first_ready got %b exp 1000", bus.in_ready); end
    cycle();
    checks++; if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 2'd3, 4'hB}) begin errors++; $display("[TB] FAIL rm_first_beat got v%b s%0d d%h exp v1 s3 dB", bus.out_valid, bus.out_sel, bus.out_data); end
    applyStimulus(4'b1001, 4'b0001, 4'd1, 4'd0, 4'd0, 4'hC, 1'b1);
    checks++; if (bus.in_ready !== 4'b1000) begin errors++; $display("[TB] FAIL rm_locked_ready got %b exp 1000", bus.in_ready); end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    checks++; if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b0, 2'd0, 4'd0}) begin errors++; $display("[TB] FAIL rm_after_reset got v%b s%0d d%0d exp v0 s0 d0", bus.out_valid, bus.out_sel, bus.out_data); end
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rm_unlocked_ready got %b exp 0001", bus.in_ready); end
    cycle();
    checks++; if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 2'd0, 4'd1}) begin errors++; $display("[TB] FAIL rm_req0_beat got v%b s%0d d%0d exp v1 s0 d1", bus.out_valid, bus.out_sel, bus.out_data); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    test_reset();
    test_round_robin();
    test_multi_beat();
    test_owner_bubble();
    test_backpressure();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_packet_mux_arbiter.md
Name: rr_packet_mux_arbiter

Overview:
- Shares one WIDTH-bit output channel among four requesters.
- Arbitration is round-robin at packet granularity: a granted requester keeps the channel until its last beat is accepted.
- Internally this is a 4:1 data select (2-bit select) followed by a registered valid/ready output stage.
- Sits in front of any single-consumer datapath that is fed by four producers.

Parameters:
WIDTH  4  data width of each requester beat and of out_data

Ports:
clk        input   1      clock; all state updates on rising edge
rst_n      input   1      synchronous reset, active-low
in_valid   input   4      per-requester beat valid; bit i belongs to requester i
in_last    input   4      per-requester last-beat-of-packet flag; qualified by in_valid[i]
d0         input   WIDTH  requester 0 data
d1         input   WIDTH  requester 1 data
d2         input   WIDTH  requester 2 data
d3         input   WIDTH  requester 3 data
in_ready   output  4      per-requester accept, combinational; at most one bit set per cycle
out_valid  output  1      output beat valid (registered)
out_data   output  WIDTH  output beat data (registered)
out_last   output  1      output last flag (registered)
out_sel    output  2      index of the requester that sourced the current output beat (registered)
out_ready  input   1      downstream accept

Behaviour:
- Reset: synchronous, sampled on rising clk with rst_n=0. It overrides all other activity.
  - Outputs after reset: out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Internal state after reset: locked=0, owner=0, ptr=0.
- Internal state:
  - locked: 1 while a packet is in progress.
  - owner[1:0]: requester that holds the channel.
  - ptr[1:0]: highest-priority requester for the next fresh arbitration.
- Definitions:
  - load = !out_valid || out_ready (the output register can take a new beat this cycle).
  - winner = first i with in_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- in_ready (combinational):
  - When load=0: all bits 0.
  - locked=1: in_ready[i]=1 only for i==owner, regardless of that requester's in_valid.
  - locked=0: in_ready[i]=1 only for i==winner, and only if any in_valid bit is set.
  - in_ready depends combinationally on out_ready and in_valid; no combinational path from in_valid to out_*.
- Accept (beat taken from requester i) = in_valid[i] && in_ready[i]. On the next clock edge:
  - out_valid<=1, out_data<=d_i, out_last<=in_last[i], out_sel<=i.
  - If in_last[i]=1: locked<=0 and ptr<=i+1 (mod 4; requester 3 wraps to 0).
  - If in_last[i]=0: locked<=1 and owner<=i.
- load=1 with no accept: out_valid<=0; out_data, out_last and out_sel hold their values.
- load=0 (out_valid=1, out_ready=0): all output registers and internal state hold; no requester is accepted.
- Locked owner not valid: the output drains and a bubble appears. No other requester is granted and the lock is held until the owner's last beat.
- Single-beat packet (in_last=1 on the first beat): granted and released in the same cycle, so the lock never asserts.
- Latency and throughput: one cycle from accept to out_valid. Sustains one beat per cycle when out_ready=1.
- Fairness: each requester waits at most 3 packets before it is served.
- A requester that drops in_valid before it is granted simply loses that arbitration; no state is kept for it.
- Data ordering: beats of one packet leave in order and are never interleaved with beats of another requester.
- Reset mid-packet: the lock is discarded and any in-flight output beat is dropped (out_valid=0). Requesters must restart their packets.

Test Plan:
1. Reset, then in_valid=0000 for 5 cycles -> in_ready=0000, out_valid=0, out_data=0, out_sel=0 throughout.
2. All four requesters send single-beat packets (in_last=1111, d_i=i+1) continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0,…; out_data 1,2,3,4,1,…; one beat per cycle.
3. Requester 2 sends a 3-beat packet A,B,C (last on C) while requesters 0 and 3 are valid -> out_data A,B,C back-to-back with out_sel=2. Next grant is requester 3, then 0; no interleaving.
4. Requester 1 is locked mid-packet and drops in_valid for 2 cycles while requester 0 is valid -> in_ready stays 0010 only; out_valid goes 0 for 2 cycles; requester 0 is granted only after requester 1's last beat.
5. out_ready=0 for 3 cycles with out_valid=1 -> out_data, out_sel and out_last stable; in_ready=0000; the beat transfers on the first cycle out_ready=1.
6. rst_n=0 for one cycle during requester 3's multi-beat packet -> out_valid=0 next cycle; the lock clears. The next arbitration starts from ptr=0, so requester 0 wins if valid.
